// File: rtl/au_updown_counter.sv
// Loadable up/down counter with a programmable upper limit and wrap/saturate boundary modes.
// The +1/-1 step comes from AU_incdec; the counter only muxes boundary values over it.

module AU_incdec #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic             inc_dec,
    output logic [WIDTH-1:0] y
);
    // Bit i flips when every lower bit propagates: all ones for +1, all zeros for -1.
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] carry;

    assign prop = inc_dec ? ~a : a;

    always_comb begin : prefix
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] nxt;
        int               s;
        int               j;
        cur = prop;
        nxt = prop;
        s   = 0;
        j   = 0;
        if (ARCH == 2) begin
            for (int i = 1; i < WIDTH; i++) begin
                cur[i] = cur[i] & cur[i-1];
            end
        end else begin
            // ARCH 0 is Kogge-Stone (span doubling); ARCH 1 is Sklansky (divide and conquer).
            for (int k = 0; (1 << k) < WIDTH; k++) begin
                s   = 1 << k;
                nxt = cur;
                for (int i = 0; i < WIDTH; i++) begin
                    if (ARCH == 0) begin
                        j = (i >= s) ? i - s : i;
                        if (i >= s) nxt[i] = cur[i] & cur[j];
                    end else begin
                        j = (((i >> k) & 1) == 1) ? ((i >> k) << k) - 1 : i;
                        if (((i >> k) & 1) == 1) nxt[i] = cur[i] & cur[j];
                    end
                end
                cur = nxt;
            end
        end
        carry[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            carry[i] = cur[i-1];
        end
    end

    assign y = a ^ carry;
endmodule

module au_updown_counter #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dn,
    input  logic             sat,
    input  logic [WIDTH-1:0] lim,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf,
    output logic             zero,
    output logic             at_lim
);
    logic [WIDTH-1:0] step;

    AU_incdec #(
        .WIDTH(WIDTH),
        .ARCH (ARCH)
    ) u_incdec (
        .a      (cnt),
        .inc_dec(dn),
        .y      (step)
    );

    assign zero   = (cnt == '0);
    assign at_lim = (cnt >= lim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else if (load) begin
            cnt <= load_val;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else if (en) begin
            if (!dn) begin
                if (!at_lim) begin
                    cnt <= step;
                    tc  <= 1'b0;
                end else begin
                    tc <= 1'b1;
                    if (sat) begin
                        cnt <= lim;
                    end else begin
                        cnt <= '0;
                        ovf <= 1'b1;
                    end
                end
            end else begin
                // Counting down ignores lim except as the wrap target from zero.
                if (!zero) begin
                    cnt <= step;
                    tc  <= 1'b0;
                end else begin
                    tc <= 1'b1;
                    if (!sat) begin
                        cnt <= lim;
                        ovf <= 1'b1;
                    end
                end
            end
        end else begin
            tc <= 1'b0;
        end
    end
endmodule

// File: tb/tb_au_updown_counter.sv
// Bench for au_updown_counter: directed scenarios on an 8-bit instance, then a randomized
// regression over every ARCH and WIDTH in {1,3,8,16} against a plain arithmetic model.

module tb_au_updown_counter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic rnd_on;

    // directed instance signals
    logic       d_clr, d_load, d_en, d_dn, d_sat;
    logic [7:0] d_load_val, d_lim;
    logic [7:0] d_cnt;
    logic       d_tc, d_ovf, d_zero, d_at_lim;

    // shared random stimulus, truncated per width
    logic        r_clr, r_load, r_en, r_dn, r_sat;
    logic [15:0] r_lim, r_load_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    au_updown_counter #(.WIDTH(8), .ARCH(0)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (d_clr),
        .load    (d_load),
        .load_val(d_load_val),
        .en      (d_en),
        .dn      (d_dn),
        .sat     (d_sat),
        .lim     (d_lim),
        .cnt     (d_cnt),
        .tc      (d_tc),
        .ovf     (d_ovf),
        .zero    (d_zero),
        .at_lim  (d_at_lim)
    );

    for (genvar gw = 0; gw < 4; gw++) begin : g_w
        localparam int W = (gw == 0) ? 1 : (gw == 1) ? 3 : (gw == 2) ? 8 : 16;
        localparam int MASK = (1 << W) - 1;
        for (genvar ga = 0; ga < 3; ga++) begin : g_a
            logic [W-1:0] g_cnt;
            logic         g_tc, g_ovf, g_zero, g_at_lim;
            int           m_cnt;
            bit           m_tc, m_ovf;

            au_updown_counter #(.WIDTH(W), .ARCH(ga)) u_rnd (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr     (r_clr),
                .load    (r_load),
                .load_val(r_load_val[W-1:0]),
                .en      (r_en),
                .dn      (r_dn),
                .sat     (r_sat),
                .lim     (r_lim[W-1:0]),
                .cnt     (g_cnt),
                .tc      (g_tc),
                .ovf     (g_ovf),
                .zero    (g_zero),
                .at_lim  (g_at_lim)
            );

            always @(posedge clk or negedge rst_n) begin
                int lm;
                int ld;
                lm = int'(r_lim) & MASK;
                ld = int'(r_load_val) & MASK;
                if (!rst_n) begin
                    m_cnt <= 0; m_tc <= 0; m_ovf <= 0;
                end else if (r_clr) begin
                    m_cnt <= 0; m_tc <= 0; m_ovf <= 0;
                end else if (r_load) begin
                    m_cnt <= ld; m_tc <= 0; m_ovf <= 0;
                end else if (r_en && !r_dn) begin
                    if (m_cnt < lm) begin
                        m_cnt <= m_cnt + 1; m_tc <= 0;
                    end else if (r_sat) begin
                        m_cnt <= lm; m_tc <= 1;
                    end else begin
                        m_cnt <= 0; m_tc <= 1; m_ovf <= 1;
                    end
                end else if (r_en && r_dn) begin
                    if (m_cnt > 0) begin
                        m_cnt <= m_cnt - 1; m_tc <= 0;
                    end else if (r_sat) begin
                        m_tc <= 1;
                    end else begin
                        m_cnt <= lm; m_tc <= 1; m_ovf <= 1;
                    end
                end else begin
                    m_tc <= 0;
                end
            end

            always @(negedge clk) begin
                if (rnd_on) begin
                    chk($sformatf("w%0d_a%0d_cnt", W, ga), 32'(g_cnt), 32'(m_cnt));
                    chk($sformatf("w%0d_a%0d_tc", W, ga), 32'(g_tc), 32'(m_tc));
                    chk($sformatf("w%0d_a%0d_ovf", W, ga), 32'(g_ovf), 32'(m_ovf));
                    chk($sformatf("w%0d_a%0d_zero", W, ga), 32'(g_zero), 32'(m_cnt == 0));
                    chk($sformatf("w%0d_a%0d_at_lim", W, ga), 32'(g_at_lim),
                        32'(m_cnt >= (int'(r_lim) & MASK)));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_d(input string tag, input int c, input int t, input int o);
        chk({tag, "_cnt"}, 32'(d_cnt), 32'(c));
        chk({tag, "_tc"}, 32'(d_tc), 32'(t));
        chk({tag, "_ovf"}, 32'(d_ovf), 32'(o));
    endtask

    task automatic set_d(input logic c, input logic l, input logic [7:0] lv, input logic e,
                         input logic d, input logic s, input logic [7:0] lm);
        d_clr = c; d_load = l; d_load_val = lv; d_en = e; d_dn = d; d_sat = s; d_lim = lm;
    endtask

    task automatic randomize_inputs();
        int sel;
        r_clr  = ($urandom_range(0, 31) == 0);
        r_load = ($urandom_range(0, 15) == 0);
        r_en   = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) r_dn = ~r_dn;
        r_sat  = $urandom_range(0, 1) == 1;
        sel    = $urandom_range(0, 7);
        if ($urandom_range(0, 3) == 0) begin
            case (sel)
                0:       r_lim = 16'h0;
                1:       r_lim = 16'hFFFF;
                2, 3, 4: r_lim = 16'($urandom_range(0, 7));
                default: r_lim = 16'($urandom);
            endcase
        end
        r_load_val = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 12)) : 16'($urandom);
    endtask

    initial begin
        checks = 0; errors = 0; rnd_on = 1'b0;
        r_clr = 0; r_load = 0; r_en = 0; r_dn = 0; r_sat = 0; r_lim = '0; r_load_val = '0;
        set_d(0, 0, 8'd0, 0, 0, 0, 8'd0);
        rst_n = 1'b0;
        #12;
        chk_d("reset", 0, 0, 0);
        chk("reset_zero", 32'(d_zero), 32'd1);
        @(negedge clk) rst_n = 1'b1;

        // up-wrap at lim=5
        set_d(0, 0, 8'd0, 1, 0, 0, 8'd5);
        for (int i = 0; i < 8; i++) begin
            int exp_c [8] = '{1, 2, 3, 4, 5, 0, 1, 2};
            tick();
            chk_d($sformatf("upwrap%0d", i), exp_c[i], (i == 5) ? 1 : 0, (i >= 5) ? 1 : 0);
        end

        // up-saturate from 3
        set_d(0, 1, 8'd3, 0, 0, 1, 8'd5);
        tick();
        chk_d("upsat_load", 3, 0, 0);
        set_d(0, 0, 8'd0, 1, 0, 1, 8'd5);
        for (int i = 0; i < 4; i++) begin
            int exp_c [4] = '{4, 5, 5, 5};
            tick();
            chk_d($sformatf("upsat%0d", i), exp_c[i], (i >= 2) ? 1 : 0, 0);
            chk($sformatf("upsat%0d_at_lim", i), 32'(d_at_lim), (i >= 1) ? 32'd1 : 32'd0);
        end

        // down-wrap then down-saturate
        set_d(0, 1, 8'd1, 0, 1, 0, 8'd9);
        tick();
        set_d(0, 0, 8'd0, 1, 1, 0, 8'd9);
        tick();
        chk_d("dnwrap0", 0, 0, 0);
        tick();
        chk_d("dnwrap1", 9, 1, 1);
        set_d(0, 1, 8'd0, 0, 1, 1, 8'd9);
        tick();
        set_d(0, 0, 8'd0, 1, 1, 1, 8'd9);
        tick();
        chk_d("dnsat", 0, 1, 0);
        chk("dnsat_zero", 32'(d_zero), 32'd1);

        // priority and loads above the limit
        set_d(1, 1, 8'd55, 1, 0, 0, 8'd10);
        tick();
        chk_d("prio_clr", 0, 0, 0);
        set_d(0, 1, 8'd200, 1, 0, 0, 8'd10);
        tick();
        chk_d("prio_load", 200, 0, 0);
        chk("prio_load_at_lim", 32'(d_at_lim), 32'd1);
        set_d(0, 0, 8'd0, 1, 0, 0, 8'd10);
        tick();
        chk_d("above_wrap", 0, 1, 1);
        set_d(0, 1, 8'd200, 0, 0, 1, 8'd10);
        tick();
        set_d(0, 0, 8'd0, 1, 0, 1, 8'd10);
        tick();
        chk_d("above_sat", 10, 1, 0);

        // async reset while counting
        set_d(0, 1, 8'd6, 0, 0, 0, 8'd6);
        tick();
        set_d(0, 0, 8'd0, 1, 0, 0, 8'd6);
        tick();
        set_d(0, 0, 8'd0, 1, 0, 0, 8'd200);
        repeat (7) tick();
        chk_d("pre_rst", 7, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_d("mid_rst", 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk_d("post_rst", 1, 0, 0);

        // randomized regression over all widths and architectures
        @(posedge clk);
        #2 rst_n = 1'b0;
        rnd_on = 1'b1;
        #1 rst_n = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            @(posedge clk);
            #2;
            randomize_inputs();
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        // free-running wrap at the all-ones limit (WIDTH=1 toggles 1,0)
        @(posedge clk);
        #2;
        r_clr = 1; r_load = 0; r_en = 0; r_dn = 0; r_sat = 0; r_lim = 16'hFFFF;
        @(posedge clk);
        #2;
        r_clr = 0; r_en = 1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        #1 rnd_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
